// File: rtl/odesa_event_sequencer.sv
// Latency-coded spike-pattern player: replays stored samples as one-clock channel events plus a one-hot label.
// First event 2 clocks after start; free-running source with no backpressure, only i_stop aborts playback.
module odesa_event_sequencer #(
    parameter int p_channels      = 4,
    parameter int p_classes       = 3,
    parameter int p_width         = 8,
    parameter int p_sample_num    = 45,
    parameter int p_sample_len    = 30,
    parameter int p_spike_delay   = 10,
    parameter int p_pattern_delay = 800,
    parameter int p_epochs        = 401,
    localparam int c_aw = (p_sample_num > 1) ? $clog2(p_sample_num) : 1,
    localparam int c_lw = (p_classes > 1) ? $clog2(p_classes) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic [c_aw-1:0]               i_wr_addr,
    input  logic [p_channels*p_width-1:0] i_wr_times,
    input  logic [c_lw-1:0]               i_wr_label,
    input  logic                          i_start,
    input  logic                          i_stop,
    output logic [p_channels-1:0]         o_event,
    output logic [p_classes-1:0]          o_label,
    output logic                          o_label_valid,
    output logic [c_aw-1:0]               o_sample_idx,
    output logic [15:0]                   o_epoch,
    output logic                          o_busy,
    output logic                          o_done
);

    localparam int c_tw = $clog2(p_sample_len + 1);
    localparam int c_sw = $clog2(p_spike_delay + 1);
    localparam int c_gw = (p_pattern_delay > 0) ? $clog2(p_pattern_delay + 1) : 1;

    localparam logic [c_tw-1:0] c_tick_last = c_tw'(p_sample_len - 1);
    localparam logic [c_sw-1:0] c_sub_last  = c_sw'(p_spike_delay - 1);
    localparam logic [c_gw-1:0] c_gap_last  = (p_pattern_delay > 0) ? c_gw'(p_pattern_delay - 1) : '0;
    localparam logic [c_aw-1:0] c_idx_last  = c_aw'(p_sample_num - 1);
    localparam logic [15:0]     c_epochs    = 16'(p_epochs);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    logic [p_channels*p_width-1:0] mem_times [p_sample_num];
    logic [c_lw-1:0]               mem_label [p_sample_num];

    state_t                        state_q, state_d;
    logic [c_aw-1:0]               idx_q, idx_d;
    logic [15:0]                   epoch_q, epoch_d;
    logic [c_tw-1:0]               tick_q, tick_d;
    logic [c_sw-1:0]               sub_q, sub_d;
    logic [c_gw-1:0]               gap_q, gap_d;
    logic [p_channels*p_width-1:0] times_q, times_d;
    logic [p_classes-1:0]          label_q, label_d;
    logic [p_channels-1:0]         event_q, event_d;
    logic                          vld_q, vld_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          advance;

    function automatic logic [p_classes-1:0] to_onehot(input logic [c_lw-1:0] l);
        logic [p_classes-1:0] v;
        v = '0;
        for (int k = 0; k < p_classes; k++) begin
            if (32'(l) == k) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Sample memory is only writable while idle and is deliberately never cleared by reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && state_q == ST_IDLE && i_wr_en && (32'(i_wr_addr) < p_sample_num)) begin
            mem_times[i_wr_addr] <= i_wr_times;
            mem_label[i_wr_addr] <= i_wr_label;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        tick_d  = tick_q;
        sub_d   = sub_q;
        gap_d   = gap_q;
        times_d = times_q;
        label_d = label_q;
        advance = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    epoch_d = '0;
                end
            end
            ST_FETCH: begin
                times_d = mem_times[idx_q];
                label_d = to_onehot(mem_label[idx_q]);
                tick_d  = '0;
                sub_d   = '0;
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (sub_q == c_sub_last) begin
                    sub_d = '0;
                    if (tick_q == c_tick_last) begin
                        if (p_pattern_delay > 0) begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + c_tw'(1);
                    end
                end else begin
                    sub_d = sub_q + c_sw'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == c_gap_last) advance = 1'b1;
                else                     gap_d   = gap_q + c_gw'(1);
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (idx_q != c_idx_last) begin
                idx_d   = idx_q + c_aw'(1);
                state_d = ST_FETCH;
            end else begin
                idx_d   = '0;
                epoch_d = (epoch_q == 16'hFFFF) ? epoch_q : epoch_q + 16'd1;
                state_d = (p_epochs != 0 && epoch_d == c_epochs) ? ST_DONE : ST_FETCH;
            end
        end

        if (i_stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            label_d = '0;
        end

        // Tick never reaches p_sample_len, so out-of-window times cannot match.
        for (int c = 0; c < p_channels; c++) begin
            event_d[c] = (state_d == ST_PLAY) && (sub_d == '0) &&
                         (times_d[c*p_width +: p_width] != {p_width{1'b1}}) &&
                         (32'(times_d[c*p_width +: p_width]) == 32'(tick_d));
        end
        vld_d  = (state_d == ST_PLAY);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            epoch_q <= '0;
            tick_q  <= '0;
            sub_q   <= '0;
            gap_q   <= '0;
            times_q <= '0;
            label_q <= '0;
            event_q <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            tick_q  <= tick_d;
            sub_q   <= sub_d;
            gap_q   <= gap_d;
            times_q <= times_d;
            label_q <= label_d;
            event_q <= event_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_event       = event_q;
    assign o_label       = label_q;
    assign o_label_valid = vld_q;
    assign o_sample_idx  = idx_q;
    assign o_epoch       = epoch_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;

endmodule

// File: tb/tb_odesa_event_sequencer.sv
// Two sequencers (gap 3 / 3 epochs, and gap 0 / 1 epoch) share stimulus and are checked
// every cycle against a window-arithmetic model, plus hand-derived literal expectations.
module tb_odesa_event_sequencer;
    localparam int C = 4, K = 3, W = 8, N = 2, L = 4, D = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1, wr_en = 1'b0, start = 1'b0, stop = 1'b0;
    logic [0:0]     wr_addr = '0;
    logic [C*W-1:0] wr_times = '0;
    logic [1:0]     wr_label = '0;

    logic [C-1:0] ev_a, ev_b;
    logic [K-1:0] lab_a, lab_b;
    logic         vld_a, vld_b, busy_a, busy_b, done_a, done_b;
    logic [0:0]   idx_a, idx_b;
    logic [15:0]  ep_a, ep_b;

    odesa_event_sequencer #(.p_channels(C), .p_classes(K), .p_width(W), .p_sample_num(N),
        .p_sample_len(L), .p_spike_delay(D), .p_pattern_delay(3), .p_epochs(3)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_times(wr_times),
        .i_wr_label(wr_label), .i_start(start), .i_stop(stop), .o_event(ev_a), .o_label(lab_a),
        .o_label_valid(vld_a), .o_sample_idx(idx_a), .o_epoch(ep_a), .o_busy(busy_a), .o_done(done_a));

    odesa_event_sequencer #(.p_channels(C), .p_classes(K), .p_width(W), .p_sample_num(N),
        .p_sample_len(L), .p_spike_delay(D), .p_pattern_delay(0), .p_epochs(1)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_times(wr_times),
        .i_wr_label(wr_label), .i_start(start), .i_stop(stop), .o_event(ev_b), .o_label(lab_b),
        .o_label_valid(vld_b), .o_sample_idx(idx_b), .o_epoch(ep_b), .o_busy(busy_b), .o_done(done_b));

    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    bit live = 1'b0;

    // Model state: a run is a counter of clocks since the FETCH that followed start.
    bit           running [2];
    int           run_cnt [2];
    int           hold_ep [2];
    int           hold_idx [2];
    logic [K-1:0] hold_lab [2];
    int           m_time [2][N][C];
    int           m_lab [2][N];

    function automatic int gap_of(input int i);
        return (i == 0) ? 3 : 0;
    endfunction

    function automatic int epochs_of(input int i);
        return (i == 0) ? 3 : 1;
    endfunction

    function automatic logic [K-1:0] onehot(input int l);
        logic [K-1:0] v;
        v = '0;
        for (int k = 0; k < K; k++) if (l == k) v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each sample occupies one period: 1 FETCH clock, L*D PLAY clocks, then the gap.
    task automatic model_out(input int i, output logic [C-1:0] e_ev, output bit e_vld,
                             output bit e_busy, output bit e_done, output int e_ep,
                             output int e_idx, output logic [K-1:0] e_lab, output bit lab_known);
        int per, n, r, p;
        e_ev = '0; e_vld = 0; e_busy = 0; e_done = 0;
        e_ep = hold_ep[i]; e_idx = hold_idx[i]; e_lab = hold_lab[i]; lab_known = 1;
        if (running[i]) begin
            per = 1 + L*D + gap_of(i);
            e_busy = 1;
            if (epochs_of(i) != 0 && run_cnt[i] == epochs_of(i)*N*per) begin
                e_done = 1; e_ep = epochs_of(i); e_idx = 0;
                e_lab = onehot(m_lab[i][N-1]);
            end else begin
                n = run_cnt[i] / per;
                r = run_cnt[i] % per;
                e_ep = n / N;
                e_idx = n % N;
                e_lab = onehot(m_lab[i][e_idx]);
                if (r == 0) lab_known = 0;
                else if (r <= L*D) begin
                    p = r - 1;
                    e_vld = 1;
                    for (int c = 0; c < C; c++)
                        e_ev[c] = (p % D == 0) && (m_time[i][e_idx][c] == p / D);
                end
            end
        end
    endtask

    logic [C-1:0] u_ev;
    bit           u_vld, u_busy, u_done, u_lk;
    int           u_ep, u_idx;
    logic [K-1:0] u_lab;

    always @(posedge clk) begin
        live = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                running[i] = 0; hold_ep[i] = 0; hold_idx[i] = 0; hold_lab[i] = '0;
            end else if (running[i]) begin
                model_out(i, u_ev, u_vld, u_busy, u_done, u_ep, u_idx, u_lab, u_lk);
                if (stop || u_done) begin
                    running[i] = 0;
                    hold_ep[i] = u_ep;
                    hold_idx[i] = u_idx;
                    hold_lab[i] = stop ? '0 : u_lab;
                end else begin
                    run_cnt[i]++;
                end
            end else begin
                if (wr_en) begin
                    for (int c = 0; c < C; c++) m_time[i][wr_addr][c] = int'(wr_times[c*W +: W]);
                    m_lab[i][wr_addr] = int'(wr_label);
                end
                if (start && !stop) begin
                    running[i] = 1;
                    run_cnt[i] = 0;
                end
            end
        end
    end

    task automatic check_inst(input int i, input logic [C-1:0] ev, input logic vld,
                              input logic [K-1:0] lab, input logic [0:0] idx, input logic [15:0] ep,
                              input logic busy, input logic done);
        logic [C-1:0] e_ev;
        bit           e_vld, e_busy, e_done, lk;
        int           e_ep, e_idx;
        logic [K-1:0] e_lab;
        model_out(i, e_ev, e_vld, e_busy, e_done, e_ep, e_idx, e_lab, lk);
        chk($sformatf("inst%0d o_event", i), 32'(ev), 32'(e_ev));
        chk($sformatf("inst%0d o_label_valid", i), 32'(vld), 32'(e_vld));
        chk($sformatf("inst%0d o_busy", i), 32'(busy), 32'(e_busy));
        chk($sformatf("inst%0d o_done", i), 32'(done), 32'(e_done));
        chk($sformatf("inst%0d o_epoch", i), 32'(ep), e_ep);
        chk($sformatf("inst%0d o_sample_idx", i), 32'(idx), e_idx);
        if (lk) chk($sformatf("inst%0d o_label", i), 32'(lab), 32'(e_lab));
    endtask

    always @(negedge clk) begin
        if (live) begin
            check_inst(0, ev_a, vld_a, lab_a, idx_a, ep_a, busy_a, done_a);
            check_inst(1, ev_b, vld_b, lab_b, idx_b, ep_b, busy_b, done_b);
        end
    end

    task automatic next_cyc();
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic at_cycle(input int k);
        while (cyc < k) next_cyc();
        @(negedge clk);
    endtask

    task automatic start_run();
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        cyc = 1;
    endtask

    task automatic write_sample(input int addr, input logic [7:0] t0, input logic [7:0] t1,
                                input logic [7:0] t2, input logic [7:0] t3, input int lbl);
        wr_en = 1'b1;
        wr_addr = 1'(addr);
        wr_times = {t3, t2, t1, t0};
        wr_label = 2'(lbl);
        next_cyc();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy_a || busy_b) && k < 400);
        chk("idle within budget", 32'(busy_a || busy_b), 32'd0);
        next_cyc();
    endtask

    function automatic logic [7:0] rand_time();
        int v;
        v = $urandom_range(0, 6);
        return (v == 6) ? 8'hFF : 8'(v);
    endfunction

    initial begin
        int cnt, act, at;
        repeat (3) next_cyc();
        @(negedge clk);
        chk("reset busy", 32'(busy_a), 0);
        chk("reset event", 32'(ev_a), 0);
        chk("reset epoch", 32'(ep_a), 0);
        chk("reset label", 32'(lab_a), 0);
        next_cyc();
        rst = 1'b0;

        write_sample(0, 8'd0, 8'd1, 8'd3, 8'hFF, 2);
        write_sample(1, 8'd2, 8'd2, 8'd0, 8'd1, 0);

        // Basic playback, multi-epoch, zero gap, and a write attempt while playing.
        start_run();
        at_cycle(2);  chk("s0 ch0 at 2", 32'(ev_a), 32'b0001);
                      chk("s0 label", 32'(lab_a), 32'b100);
                      chk("s0 valid", 32'(vld_a), 1);
        at_cycle(3);  chk("no event at 3", 32'(ev_a), 0);
        at_cycle(4);  chk("s0 ch1 at 4", 32'(ev_a), 32'b0010);
        while (cyc < 5) next_cyc();
        wr_en = 1'b1; wr_addr = 1'b0; wr_times = {4{8'd3}}; wr_label = 2'd1;
        next_cyc();
        wr_en = 1'b0;
        at_cycle(8);  chk("s0 ch2 at 8", 32'(ev_a), 32'b0100);
        at_cycle(9);  chk("nogap last play", 32'(vld_b), 1);
        at_cycle(10); chk("nogap fetch valid", 32'(vld_b), 0);
                      chk("nogap fetch busy", 32'(busy_b), 1);
        at_cycle(11); chk("nogap s1 ch2", 32'(ev_b), 32'b0100);
        at_cycle(14); chk("s1 ch2 at 14", 32'(ev_a), 32'b0100);
                      chk("s1 label", 32'(lab_a), 32'b001);
        at_cycle(16); chk("s1 ch3 at 16", 32'(ev_a), 32'b1000);
        at_cycle(18); chk("s1 ch0+ch1 at 18", 32'(ev_a), 32'b0011);
        at_cycle(19); chk("nogap done", 32'(done_b), 1);
        at_cycle(20); chk("nogap busy fall", 32'(busy_b), 0);
        at_cycle(25); chk("epoch 1", 32'(ep_a), 1);
        at_cycle(26); chk("epoch2 replay unchanged", 32'(ev_a), 32'b0001);
        at_cycle(49); chk("epoch 2", 32'(ep_a), 2);
        at_cycle(72); chk("no early done", 32'(done_a), 0);
        at_cycle(73); chk("done pulse", 32'(done_a), 1);
                      chk("final epoch", 32'(ep_a), 3);
        at_cycle(74); chk("busy falls after done", 32'(busy_a), 0);
                      chk("done single clock", 32'(done_a), 0);
        wait_idle();

        // Stop in the middle of epoch 1, sample 1.
        start_run();
        at_cycle(38); chk("pre-stop epoch", 32'(ep_a), 1);
                      chk("pre-stop idx", 32'(idx_a), 1);
        while (cyc < 39) next_cyc();
        stop = 1'b1;
        next_cyc();
        stop = 1'b0;
        at_cycle(40); chk("stop busy", 32'(busy_a), 0);
                      chk("stop event", 32'(ev_a), 0);
                      chk("stop valid", 32'(vld_a), 0);
                      chk("stop no done", 32'(done_a), 0);
        next_cyc();
        start_run();
        at_cycle(1);  chk("restart epoch", 32'(ep_a), 0);
                      chk("restart idx", 32'(idx_a), 0);
        at_cycle(2);  chk("restart s0 ch0", 32'(ev_a), 32'b0001);
        wait_idle();

        // Start and stop together while idle.
        start = 1'b1; stop = 1'b1;
        next_cyc();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("start+stop stays idle a", 32'(busy_a), 0);
        chk("start+stop stays idle b", 32'(busy_b), 0);
        next_cyc();

        // Out-of-window time on channel 0 in both samples.
        write_sample(0, 8'd5, 8'd1, 8'd2, 8'd0, 1);
        write_sample(1, 8'd5, 8'd0, 8'd3, 8'd3, 2);
        start_run();
        cnt = 0;
        for (int k = 0; k < 400 && (busy_a || busy_b || k == 0); k++) begin
            @(negedge clk);
            if (ev_a[0]) cnt++;
        end
        chk("time 5 never fires", 32'(cnt), 0);
        wait_idle();

        // Reset mid-playback keeps memory but clears the run.
        start_run();
        while (cyc < 30) next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        at_cycle(31); chk("mid reset busy", 32'(busy_a), 0);
                      chk("mid reset epoch", 32'(ep_a), 0);
                      chk("mid reset label", 32'(lab_a), 0);
        next_cyc();
        start_run();
        wait_idle();

        for (int r = 0; r < 8; r++) begin
            for (int s = 0; s < N; s++)
                write_sample(s, rand_time(), rand_time(), rand_time(), rand_time(), $urandom_range(0, 2));
            start_run();
            act = $urandom_range(0, 2);
            at = $urandom_range(2, 70);
            for (int k = 0; k < at; k++) begin
                wr_en = ($urandom_range(0, 7) == 0);
                wr_addr = 1'($urandom_range(0, 1));
                wr_times = $urandom;
                wr_label = 2'($urandom_range(0, 2));
                start = ($urandom_range(0, 7) == 0);
                next_cyc();
            end
            wr_en = 1'b0;
            start = 1'b0;
            if (act == 1) stop = 1'b1;
            else if (act == 2) rst = 1'b1;
            next_cyc();
            stop = 1'b0;
            rst = 1'b0;
            wait_idle();
        end

        repeat (2) next_cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
